rom_burst_reader: RTL and testbench

- AXI4 read master that sits directly upstream of the ROM slave wrapper.
- Accepts a copy request (start byte address, word count) from a local controller such as the boot/DMA sequencer.
- Splits the request into INCR bursts on the AR channel and consumes the R channel.
- Buffers returned words in an internal FIFO and presents them as a valid/ready word stream with a last marker.

---
 rtl/rom_rd_pkg.sv | 32 +++
 rtl/rom_rd_fifo.sv | 54 +++++
 rtl/rom_burst_reader.sv | 177 +++++++++++++++++
 tb/tb_rom_burst_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_rd_pkg.sv
// Shared types and constants for the ROM burst reader: FSM states, fixed AXI
// encodings and the burst sizing helper that keeps bursts inside a 4KB page.
package rom_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_DATA   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [2:0]  ARSIZE_WORD = 3'b010;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [12:0] PAGE_BYTES  = 13'd4096;

  // Beats for the next burst: bounded by words left, burst cap and the 4KB page.
  function automatic logic [4:0] burst_beats(input logic [15:0] remain,
                                             input logic [31:0] addr,
                                             input logic [4:0]  max_burst);
    logic [12:0] page_left;
    logic [10:0] page_words;
    logic [4:0]  b1;
    logic [4:0]  b2;
    page_left  = PAGE_BYTES - {1'b0, addr[11:0]};
    page_words = page_left[12:2];
    b1 = ({11'd0, max_burst} > remain) ? remain[4:0] : max_burst;
    b2 = ({6'd0, b1} > page_words) ? page_words[4:0] : b1;
    return b2;
  endfunction

endpackage

// File: rtl/rom_rd_fifo.sv
// Synchronous word FIFO for the reader's R-channel data; head word is visible
// combinationally on rdata whenever empty is low.
module rom_rd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     free
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign free    = CW'(DEPTH) - count;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
      else                         count <= count;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rom_burst_reader.sv
// AXI4 read master: splits a word-copy request into page-safe INCR bursts and
// streams the returned words out. Optional perf counters under ROM_RD_PERF_EN.
module rom_burst_reader
  import rom_rd_pkg::*;
#(
  parameter int         MAX_BURST  = 16,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [3:0] ARID_VAL   = 4'h0
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_words,
  output logic [3:0]  ARID_M,
  output logic [31:0] ARADDR_M,
  output logic [3:0]  ARLEN_M,
  output logic [2:0]  ARSIZE_M,
  output logic [1:0]  ARBURST_M,
  output logic        ARVALID_M,
  input  logic        ARREADY_M,
  input  logic [3:0]  RID_M,
  input  logic [31:0] RDATA_M,
  input  logic [1:0]  RRESP_M,
  input  logic        RLAST_M,
  input  logic        RVALID_M,
  output logic        RREADY_M,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef ROM_RD_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stall
`endif
);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  logic [31:0]   cur_addr;
  logic [15:0]   remain;
  logic [4:0]    burst_q;
  logic [4:0]    beat_cnt;
  logic [15:0]   total_m1;
  logic [15:0]   pop_cnt;
  logic          last_gone;
  logic [4:0]    beats_now;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_free;
  logic          r_fire;
  logic          pop_fire;
  logic          finish_ok;
  logic          unused_ok;

  assign ARID_M    = ARID_VAL;
  assign ARSIZE_M  = ARSIZE_WORD;
  assign ARBURST_M = BURST_INCR;
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign RREADY_M  = (state == ST_DATA) & ~fifo_full;
  assign r_fire    = RVALID_M & RREADY_M;
  assign out_valid = ~fifo_empty;
  assign pop_fire  = out_valid & out_ready;
  assign out_last  = out_valid & (pop_cnt == total_m1);
  assign beats_now = burst_beats(remain, cur_addr, 5'(MAX_BURST));
  assign unused_ok = ^{RID_M, req_addr[1:0]};

  // Done once the final word has left and nothing else is buffered.
  assign finish_ok = (pop_fire & out_last & (fifo_free == FW'(FIFO_DEPTH - 1))) |
                     (last_gone & fifo_empty);

  rom_rd_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (r_fire),
    .wdata (RDATA_M),
    .pop   (pop_fire),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  // Request sequencing: AR issue is credit-gated on FIFO free space.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= ST_IDLE;
      cur_addr  <= 32'd0;
      remain    <= 16'd0;
      burst_q   <= 5'd0;
      beat_cnt  <= 5'd0;
      total_m1  <= 16'd0;
      pop_cnt   <= 16'd0;
      last_gone <= 1'b0;
      ARVALID_M <= 1'b0;
      ARADDR_M  <= 32'd0;
      ARLEN_M   <= 4'd0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop_fire) begin
        pop_cnt <= pop_cnt + 16'd1;
        if (out_last) last_gone <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cur_addr  <= {req_addr[31:2], 2'b00};
            remain    <= (req_words == 16'd0) ? 16'd1 : req_words;
            total_m1  <= (req_words == 16'd0) ? 16'd0 : req_words - 16'd1;
            pop_cnt   <= 16'd0;
            last_gone <= 1'b0;
            err       <= 1'b0;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ARVALID_M) begin
            if (ARREADY_M) begin
              ARVALID_M <= 1'b0;
              beat_cnt  <= 5'd0;
              state     <= ST_DATA;
            end
          end else if (32'(fifo_free) >= 32'(beats_now)) begin
            ARVALID_M <= 1'b1;
            ARADDR_M  <= cur_addr;
            ARLEN_M   <= 4'(beats_now - 5'd1);
            burst_q   <= beats_now;
          end
        end
        ST_DATA: begin
          if (r_fire) begin
            beat_cnt <= beat_cnt + 5'd1;
            if (RRESP_M != RESP_OKAY) err <= 1'b1;
            // The burst ends on RLAST regardless of how many beats arrived.
            if (RLAST_M) begin
              cur_addr <= cur_addr + {25'd0, burst_q, 2'b00};
              remain   <= remain - {11'd0, burst_q};
              state    <= (remain == {11'd0, burst_q}) ? ST_FINISH : ST_ADDR;
            end
          end
        end
        ST_FINISH: begin
          if (finish_ok) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ROM_RD_PERF_EN
  // Activity counters, cleared when a new request is taken and saturating.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      perf_cycles <= 32'd0;
      perf_stall  <= 32'd0;
    end else if ((state == ST_IDLE) && req_valid) begin
      perf_cycles <= 32'd0;
      perf_stall  <= 32'd0;
    end else begin
      if (busy && (perf_cycles != 32'hFFFF_FFFF)) perf_cycles <= perf_cycles + 32'd1;
      if (out_valid && !out_ready && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader: AXI ROM slave model, output-word
// scoreboard, table-driven burst-split vectors and hand-written corner cases.
module tb_rom_burst_reader;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_words;
  logic [3:0]  ARID_M;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARLEN_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M;
  logic        ARVALID_M;
  logic        ARREADY_M = 1'b0;
  logic [3:0]  RID_M;
  logic [31:0] RDATA_M = 32'd0;
  logic [1:0]  RRESP_M = 2'b00;
  logic        RLAST_M = 1'b0;
  logic        RVALID_M = 1'b0;
  logic        RREADY_M;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;
`ifdef ROM_RD_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_stall;
`endif

  always #5 ACLK = ~ACLK;

  rom_burst_reader dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_words(req_words),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
`ifdef ROM_RD_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  typedef struct { logic [31:0] addr; logic [3:0] len; } ar_t;
  typedef struct { logic [31:0] data; logic last; } exp_t;
  typedef struct {
    logic [31:0] addr; logic [15:0] words; int nb;
    logic [31:0] a0, a1, a2; logic [3:0] l0, l1, l2;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ar_t  ar_log[$];
  ar_t  r_q[$];
  int   pops_at_ar[$];
  exp_t sb[$];
  int   r_beat = 0;
  int   r_word_idx = 0;
  int   err_word = -1;
  int   pop_total = 0;
  int   done_cnt = 0;
  logic out_ready_en = 1'b1;
  vec_t vecs[4];

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ROM slave: drive AR/R at negedge, account handshakes that the next posedge takes
  always @(negedge ACLK) begin
    ARREADY_M = 1'b1;
    if (r_q.size() > 0) begin
      RVALID_M = 1'b1;
      RDATA_M  = rom(r_q[0].addr + 32'(r_beat * 4));
      RLAST_M  = (r_beat == int'(r_q[0].len));
      RRESP_M  = (r_word_idx == err_word) ? 2'b10 : 2'b00;
    end else begin
      RVALID_M = 1'b0;
      RDATA_M  = 32'd0;
      RLAST_M  = 1'b0;
      RRESP_M  = 2'b00;
    end
    if (ARVALID_M && ARREADY_M) begin
      ar_log.push_back('{ARADDR_M, ARLEN_M});
      r_q.push_back('{ARADDR_M, ARLEN_M});
      pops_at_ar.push_back(pop_total);
    end
    if (RVALID_M && RREADY_M) begin
      r_word_idx++;
      if (RLAST_M) begin
        void'(r_q.pop_front());
        r_beat = 0;
      end else begin
        r_beat++;
      end
    end
  end

  // Output sink and scoreboard compare
  always @(negedge ACLK) begin
    exp_t e;
    out_ready = out_ready_en;
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      pop_total++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_word: got %h expected no word", out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [15:0] w);
    int n;
    int g;
    logic [31:0] base;
    n = (w == 16'd0) ? 1 : int'(w);
    base = {a[31:2], 2'b00};
    ar_log.delete();
    pops_at_ar.delete();
    r_word_idx = 0;
    pop_total = 0;
    done_cnt = 0;
    for (int i = 0; i < n; i++) sb.push_back('{rom(base + 32'(i * 4)), (i == n - 1)});
    req_addr = a;
    req_words = w;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 200) begin
      @(negedge ACLK);
      g++;
    end
    if (g >= 200) check("req_accept_timeout", 32'(req_ready), 32'd1);
    @(negedge ACLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int g;
    g = 0;
    while (done_cnt == 0 && g < limit) begin
      @(negedge ACLK);
      g++;
    end
    check({name, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    vecs[0] = '{32'h0000_0100, 16'd4,  1, 32'h100, 32'h0,    32'h0,  4'd3,  4'd0, 4'd0};
    vecs[1] = '{32'h0000_0000, 16'd40, 3, 32'h0,   32'h40,   32'h80, 4'd15, 4'd15, 4'd7};
    vecs[2] = '{32'h0000_0FF8, 16'd6,  2, 32'hFF8, 32'h1000, 32'h0,  4'd1,  4'd3, 4'd0};
    vecs[3] = '{32'h0000_0203, 16'd0,  1, 32'h200, 32'h0,    32'h0,  4'd0,  4'd0, 4'd0};

    ARESET = 1'b1;
    req_valid = 1'b0;
    req_addr = 32'd0;
    req_words = 16'd0;
    RID_M = 4'd0;
    repeat (3) @(negedge ACLK);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_arvalid", 32'(ARVALID_M), 32'd0);
    check("rst_araddr", ARADDR_M, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("arsize", 32'(ARSIZE_M), 32'd2);
    check("arburst", 32'(ARBURST_M), 32'd1);
    ARESET = 1'b0;
    @(negedge ACLK);

    for (int v = 0; v < 4; v++) begin
      out_ready_en = 1'b1;
      do_req(vecs[v].addr, vecs[v].words);
      wait_done($sformatf("vec%0d", v), 400);
      repeat (3) @(negedge ACLK);
      check($sformatf("vec%0d_done_once", v), 32'(done_cnt), 32'd1);
      check($sformatf("vec%0d_nbursts", v), 32'(ar_log.size()), 32'(vecs[v].nb));
      if (ar_log.size() > 0) begin
        check($sformatf("vec%0d_a0", v), ar_log[0].addr, vecs[v].a0);
        check($sformatf("vec%0d_l0", v), 32'(ar_log[0].len), 32'(vecs[v].l0));
      end
      if (vecs[v].nb > 1 && ar_log.size() > 1) begin
        check($sformatf("vec%0d_a1", v), ar_log[1].addr, vecs[v].a1);
        check($sformatf("vec%0d_l1", v), 32'(ar_log[1].len), 32'(vecs[v].l1));
      end
      if (vecs[v].nb > 2 && ar_log.size() > 2) begin
        check($sformatf("vec%0d_a2", v), ar_log[2].addr, vecs[v].a2);
        check($sformatf("vec%0d_l2", v), 32'(ar_log[2].len), 32'(vecs[v].l2));
      end
      check($sformatf("vec%0d_sb_drained", v), 32'(sb.size()), 32'd0);
      check($sformatf("vec%0d_idle", v), {30'd0, busy, req_ready}, 32'd1);
    end

    // Backpressure: FIFO fills, second burst waits for credit
    out_ready_en = 1'b0;
    do_req(32'h0, 16'd20);
    repeat (60) @(negedge ACLK);
    check("bp_one_burst", 32'(ar_log.size()), 32'd1);
    check("bp_arvalid_held", 32'(ARVALID_M), 32'd0);
    check("bp_rready_low", 32'(RREADY_M), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready_en = 1'b1;
    wait_done("bp", 400);
    check("bp_nbursts", 32'(ar_log.size()), 32'd2);
    if (ar_log.size() > 1) begin
      check("bp_a1", ar_log[1].addr, 32'h40);
      check("bp_l1", 32'(ar_log[1].len), 32'd3);
      check("bp_credit", 32'(pops_at_ar[1] >= 4), 32'd1);
    end
    check("bp_sb_drained", 32'(sb.size()), 32'd0);

    // Error response on the second beat
    repeat (2) @(negedge ACLK);
    err_word = 1;
    do_req(32'h300, 16'd4);
    wait_done("err", 200);
    check("err_set", 32'(err), 32'd1);
    repeat (5) @(negedge ACLK);
    check("err_sticky", 32'(err), 32'd1);
    check("err_sb_drained", 32'(sb.size()), 32'd0);
    err_word = -1;
    do_req(32'h0, 16'd1);
    check("err_cleared", 32'(err), 32'd0);
    wait_done("err_next", 200);

    // Reset in the middle of a 16-beat burst
    repeat (2) @(negedge ACLK);
    out_ready_en = 1'b0;
    do_req(32'h0, 16'd16);
    g = 0;
    while (r_word_idx < 5 && g < 200) begin
      @(negedge ACLK);
      g++;
    end
    check("rst_mid_reached_data", 32'(r_word_idx >= 5), 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_arvalid", 32'(ARVALID_M), 32'd0);
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    r_q.delete();
    r_beat = 0;
    sb.delete();
    ARESET = 1'b0;
    out_ready_en = 1'b1;
    repeat (2) @(negedge ACLK);
    do_req(32'h40, 16'd2);
    wait_done("post_rst", 200);
    check("post_rst_a0", (ar_log.size() > 0) ? ar_log[0].addr : 32'hDEAD_BEEF, 32'h40);
    check("post_rst_sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
